// File: rtl/rram_access_ctrl_pkg.sv
// rram_access_ctrl_pkg: state encoding and default phase lengths for the RRAM access sequencer
package rram_access_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_DVLP  = 3'd2,
    S_SENSE = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;
  localparam int DEF_PRE_CYC  = 2;
  localparam int DEF_DVLP_CYC = 3;
  localparam int DEF_SA_CYC   = 2;
  localparam int DEF_WR_CYC   = 4;
  localparam int DEF_CNT_W    = 4;
endpackage

// File: rtl/rram_phase_timer.sv
// rram_phase_timer: loadable down-counter that stops at zero and flags it
module rram_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (i_rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/rram_access_ctrl.sv
// rram_access_ctrl: sequences one RRAM read (precharge/develop/sense) or write pulse per request
module rram_access_ctrl
  import rram_access_ctrl_pkg::*;
#(
  parameter int PRE_CYC  = DEF_PRE_CYC,
  parameter int DVLP_CYC = DEF_DVLP_CYC,
  parameter int SA_CYC   = DEF_SA_CYC,
  parameter int WR_CYC   = DEF_WR_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_req_we,
  output logic o_ack,
  output logic o_busy,
  output logic o_done,
  output logic o_data_latch,
  output logic o_pre_h,
  output logic o_dvlp_h,
  output logic o_sa_en_h,
  output logic o_read_vddh,
  output logic o_write_vddh,
  output logic o_dummy_en
);
  localparam int MAX_LEN = 2**CNT_W - 1;
  if (PRE_CYC < 1 || PRE_CYC > MAX_LEN || DVLP_CYC < 1 || DVLP_CYC > MAX_LEN ||
      SA_CYC < 1 || SA_CYC > MAX_LEN || WR_CYC < 1 || WR_CYC > MAX_LEN) begin : g_bad_param
    $error("rram_access_ctrl: phase lengths must lie in 1..2**CNT_W-1");
  end
  state_t r_state, w_next;
  logic w_load, w_zero;
  logic [CNT_W-1:0] w_load_val, w_cnt;
  logic w_ack, w_busy, w_done, w_latch, w_pre, w_dvlp, w_sa, w_rd, w_wr, w_dm;
  rram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state <= S_IDLE;
      {o_ack, o_busy, o_done, o_data_latch, o_pre_h, o_dvlp_h,
       o_sa_en_h, o_read_vddh, o_write_vddh, o_dummy_en} <= '0;
    end else begin
      r_state <= w_next;
      {o_ack, o_busy, o_done, o_data_latch, o_pre_h, o_dvlp_h,
       o_sa_en_h, o_read_vddh, o_write_vddh, o_dummy_en} <=
        {w_ack, w_busy, w_done, w_latch, w_pre, w_dvlp, w_sa, w_rd, w_wr, w_dm};
    end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = i_req ? (i_req_we ? S_WRITE : S_PRE) : S_IDLE;
      S_PRE:   w_next = w_zero ? S_DVLP : S_PRE;
      S_DVLP:  w_next = w_zero ? S_SENSE : S_DVLP;
      S_SENSE: w_next = w_zero ? S_DONE : S_SENSE;
      S_WRITE: w_next = w_zero ? S_DONE : S_WRITE;
      default: w_next = S_IDLE;
    endcase
  end
  // Every phase is a distinct state, so a state change is exactly a phase entry.
  always_comb begin
    w_load     = (w_next != r_state);
    w_load_val = (w_next == S_PRE)   ? CNT_W'(PRE_CYC - 1)  :
                 (w_next == S_DVLP)  ? CNT_W'(DVLP_CYC - 1) :
                 (w_next == S_SENSE) ? CNT_W'(SA_CYC - 1)   :
                 (w_next == S_WRITE) ? CNT_W'(WR_CYC - 1)   : '0;
    w_ack   = (r_state == S_IDLE) && i_req;
    w_busy  = (w_next != S_IDLE);
    w_done  = (w_next == S_DONE);
    w_pre   = (w_next == S_PRE);
    w_dvlp  = (w_next == S_DVLP);
    w_sa    = (w_next == S_SENSE);
    w_rd    = w_dvlp || w_sa;
    w_dm    = w_rd;
    w_wr    = (w_next == S_WRITE);
    w_latch = w_sa && (w_load ? (w_load_val == '0) : (w_cnt == CNT_W'(1)));
  end
endmodule

// File: tb/tb_rram_access_ctrl.sv
// tb_rram_access_ctrl: directed checks of read/write sequencing, back-to-back, reset and exclusion
module tb_rram_access_ctrl;
  logic clk = 0, rst = 1, req = 0, we = 0;
  logic ack, busy, done, latch, pre, dvlp, sa, rd, wr, dm;
  logic ack1, busy1, done1, latch1, pre1, dvlp1, sa1, rd1, wr1, dm1;
  int checks = 0, failures = 0;
  int acks = 0, dones = 0;
  always #5 clk = ~clk;
  rram_access_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_we(we),
    .o_ack(ack), .o_busy(busy), .o_done(done), .o_data_latch(latch),
    .o_pre_h(pre), .o_dvlp_h(dvlp), .o_sa_en_h(sa), .o_read_vddh(rd),
    .o_write_vddh(wr), .o_dummy_en(dm)
  );
  rram_access_ctrl #(.PRE_CYC(1), .DVLP_CYC(1), .SA_CYC(1), .WR_CYC(1)) u_min (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_we(we),
    .o_ack(ack1), .o_busy(busy1), .o_done(done1), .o_data_latch(latch1),
    .o_pre_h(pre1), .o_dvlp_h(dvlp1), .o_sa_en_h(sa1), .o_read_vddh(rd1),
    .o_write_vddh(wr1), .o_dummy_en(dm1)
  );
  wire [9:0] v0 = {ack, busy, done, latch, pre, dvlp, sa, rd, wr, dm};
  wire [9:0] v1 = {ack1, busy1, done1, latch1, pre1, dvlp1, sa1, rd1, wr1, dm1};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Expected output vector in cycle c after an accept at edge 0 (c=1 is the ACK cycle).
  function automatic logic [9:0] ev(input bit w, input int p, input int d, input int s,
                                    input int wc, input int c);
    int t = w ? wc + 1 : p + d + s + 1;
    logic a  = (c == 1);
    logic b  = (c >= 1 && c <= t);
    logic dn = (c == t);
    logic pr = !w && c >= 1 && c <= p;
    logic dv = !w && c > p && c <= p + d;
    logic se = !w && c > p + d && c <= p + d + s;
    logic lt = !w && c == p + d + s;
    logic wp = w && c >= 1 && c <= wc;
    return {a, b, dn, lt, pr, dv, se, dv | se, wp, dv | se};
  endfunction
  task automatic run_op(input bit w, input string tag);
    req = 1; we = w;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("%s_def_c%0d", tag, c), v0, ev(w, 2, 3, 2, 4, c));
      check($sformatf("%s_min_c%0d", tag, c), v1, ev(w, 1, 1, 1, 1, c));
      if (c == 1) req = 0;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_def", v0, 0);
    check("reset_min", v1, 0);
    rst = 0;
    @(posedge clk); #1;
    check("idle_def", v0, 0);
    run_op(0, "read");
    run_op(1, "write");
    // Back-to-back with REQ held and REQ_WE flipped mid-read.
    req = 1; we = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_c%0d", c), v0, ev(0, 2, 3, 2, 4, c));
      if (c == 3) we = 1;
    end
    @(posedge clk); #1;
    check("b2b_ack2", {ack, wr, rd}, 3'b110);
    req = 0;
    repeat (12) @(posedge clk);
    #1;
    check("b2b_drained", v0 | v1, 0);
    // Reset asserted in cycle 4 of a read.
    req = 1; we = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_c%0d", c), v0, ev(0, 2, 3, 2, 4, c));
      if (c == 1) req = 0;
    end
    rst = 1;
    @(posedge clk); #1;
    check("rstmid_c5", v0, 0);
    rst = 0;
    for (int c = 6; c <= 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_quiet_c%0d", c), v0, 0);
    end
    run_op(0, "after_rst");
    // Random traffic with exclusion checks, then drain and compare ACK/DONE counts.
    for (int i = 0; i < 1000; i++) begin
      req = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      acks += int'(ack);
      dones += int'(done);
      check("mx_rd_wr", rd & wr, 0);
      check("mx_pre_dvlp", pre & dvlp, 0);
      check("mx_min", (rd1 & wr1) | (pre1 & dvlp1), 0);
    end
    req = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      acks += int'(ack);
      dones += int'(done);
    end
    check("ack_eq_done", 32'(acks), 32'(dones));
    check("ack_nonzero", 32'(acks > 0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
